// File: rtl/vga_sync_ctrl_pkg.sv
// Shared VGA timing constants (default 640x480@60) and helpers.
// Used by the sync controller and the pixel/overlay logic that follows it.
package vga_sync_ctrl_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_HD      = 640;
  localparam int DEF_HF      = 16;
  localparam int DEF_HB      = 48;
  localparam int DEF_HR      = 96;
  localparam int DEF_VD      = 480;
  localparam int DEF_VF      = 10;
  localparam int DEF_VB      = 33;
  localparam int DEF_VR      = 2;

  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_t;

  // Last count value of a scan axis made of display, porches and retrace.
  function automatic int span_max(input int d, input int f, input int b, input int r);
    return d + f + b + r - 1;
  endfunction

endpackage

// File: rtl/vga_sync_ctrl_mod_counter.sv
// Modulo-N counter with enable; wraps N-1 -> 0 and flags its last count.
module mod_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         max_tick
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  assign q        = q_q;
  assign max_tick = (q_q == LAST);

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = max_tick ? '0 : q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA scan timing: pixel strobe, h/v counters, sync pulses, video_on and frame strobe.
// hsync/vsync are registered from next-state counts so they line up with pixel_x/pixel_y.
module vga_sync_ctrl
  import vga_sync_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int HD      = DEF_HD,
  parameter int HF      = DEF_HF,
  parameter int HB      = DEF_HB,
  parameter int HR      = DEF_HR,
  parameter int VD      = DEF_VD,
  parameter int VF      = DEF_VF,
  parameter int VB      = DEF_VB,
  parameter int VR      = DEF_VR
) (
  input  logic             clk,
  input  logic             reset,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_tick
);

  localparam int H_MAX = span_max(HD, HF, HB, HR);
  localparam int V_MAX = span_max(VD, VF, VB, VR);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_DISP   = CNT_W'(HD);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(HD + HF);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HD + HF + HR - 1);
  localparam logic [CNT_W-1:0] V_DISP   = CNT_W'(VD);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(VD + VF);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VD + VF + VR - 1);

  if (H_MAX > CNT_MAX || V_MAX > CNT_MAX || CLK_DIV < 1) begin : g_bad_params
    $error("vga_sync_ctrl: timing does not fit 10-bit counters or CLK_DIV < 1");
  end

  logic [DIV_W-1:0] div_q;
  logic             div_max;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             h_max_tick;
  logic             v_max_tick;
  logic             line_end;

  mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .en       (1'b1),
    .q        (div_q),
    .max_tick (div_max)
  );

  mod_counter #(.N(H_MAX + 1), .W(CNT_W)) u_hcnt (
    .clk      (clk),
    .reset    (reset),
    .en       (p_tick),
    .q        (x_q),
    .max_tick (h_max_tick)
  );

  mod_counter #(.N(V_MAX + 1), .W(CNT_W)) u_vcnt (
    .clk      (clk),
    .reset    (reset),
    .en       (line_end),
    .q        (y_q),
    .max_tick (v_max_tick)
  );

  assign p_tick   = div_max & (div_q == DIV_LAST);
  assign line_end = p_tick & h_max_tick;

  // Mirror of the counters' next state, so the sync registers carry zero lag.
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  sync_t            sync_d;
  sync_t            sync_q;

  always_comb begin
    x_next = x_q;
    y_next = y_q;
    if (p_tick) begin
      x_next = h_max_tick ? '0 : x_q + CNT_W'(1);
    end
    if (line_end) begin
      y_next = v_max_tick ? '0 : y_q + CNT_W'(1);
    end
    sync_d.hsync = !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
    sync_d.vsync = !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '{hsync: 1'b1, vsync: 1'b1};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign hsync      = sync_q.hsync;
  assign vsync      = sync_q.vsync;
  assign video_on   = (x_q < H_DISP) && (y_q < V_DISP);
  assign frame_tick = line_end & v_max_tick;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl: three parameterisations share one clock and reset and are
// scored cycle by cycle against a pixel-index model of the scan.
module tb_vga_sync_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
    exp_t c;
  } exp3_t;

  exp3_t sb_q[$];
  int total = 0;
  int bad   = 0;

  // A: default 640x480, CLK_DIV=2.  B: tiny, CLK_DIV=1.  C: small, CLK_DIV=3.
  logic       a_pt, a_von, a_hs, a_vs, a_ft;
  logic [9:0] a_x, a_y;
  logic       b_pt, b_von, b_hs, b_vs, b_ft;
  logic [9:0] b_x, b_y;
  logic       c_pt, c_von, c_hs, c_vs, c_ft;
  logic [9:0] c_x, c_y;

  vga_sync_ctrl u_a (
    .clk(clk), .reset(rst), .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft)
  );

  vga_sync_ctrl #(.CLK_DIV(1), .HD(4), .HF(1), .HB(1), .HR(2),
                  .VD(2), .VF(1), .VB(1), .VR(1)) u_b (
    .clk(clk), .reset(rst), .p_tick(b_pt), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft)
  );

  vga_sync_ctrl #(.CLK_DIV(3), .HD(8), .HF(2), .HB(2), .HR(3),
                  .VD(6), .VF(2), .VB(1), .VR(2)) u_c (
    .clk(clk), .reset(rst), .p_tick(c_pt), .pixel_x(c_x), .pixel_y(c_y),
    .video_on(c_von), .hsync(c_hs), .vsync(c_vs), .frame_tick(c_ft)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after n clocks since the last reset edge.
  function automatic exp_t model(input int n, input int cd,
                                 input int hd, input int hf, input int hb, input int hr,
                                 input int vd, input int vf, input int vb, input int vr);
    exp_t e;
    int ht  = hd + hf + hb + hr;
    int vt  = vd + vf + vb + vr;
    int pix = n / cd;
    int x   = pix % ht;
    int y   = (pix / ht) % vt;
    e.pt  = ((n % cd) == cd - 1);
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.von = (x < hd) && (y < vd);
    e.hs  = !((x >= hd + hf) && (x < hd + hf + hr));
    e.vs  = !((y >= vd + vf) && (y < vd + vf + vr));
    e.ft  = e.pt && (x == ht - 1) && (y == vt - 1);
    return e;
  endfunction

  task automatic check_dut(input string nm, input exp_t e,
                           input logic pt, input logic [9:0] x, input logic [9:0] y,
                           input logic von, input logic hs, input logic vs, input logic ft);
    chk_val({nm, ".p_tick"},     32'(pt),  32'(e.pt));
    chk_val({nm, ".pixel_x"},    32'(x),   32'(e.x));
    chk_val({nm, ".pixel_y"},    32'(y),   32'(e.y));
    chk_val({nm, ".video_on"},   32'(von), 32'(e.von));
    chk_val({nm, ".hsync"},      32'(hs),  32'(e.hs));
    chk_val({nm, ".vsync"},      32'(vs),  32'(e.vs));
    chk_val({nm, ".frame_tick"}, 32'(ft),  32'(e.ft));
  endtask

  task automatic sb_pop_check();
    exp3_t e;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check_dut("A", e.a, a_pt, a_x, a_y, a_von, a_hs, a_vs, a_ft);
    check_dut("B", e.b, b_pt, b_x, b_y, b_von, b_hs, b_vs, b_ft);
    check_dut("C", e.c, c_pt, c_x, c_y, c_von, c_hs, c_vs, c_ft);
  endtask

  int         n        = 0;
  int         cyc      = 0;
  int         b_last_ft = -1;
  bit         prev_ok  = 1'b0;
  logic       pa_hs, pa_von;
  logic [9:0] pa_x, pa_y;

  // One clock: score the state left by the last edge, then drive reset and queue the next state.
  task automatic step(input bit r_in);
    exp3_t e;
    @(negedge clk);
    cyc++;
    sb_pop_check();
    if (rst) begin
      chk_val("A.rst_x",     32'(a_x),   32'd0);
      chk_val("A.rst_y",     32'(a_y),   32'd0);
      chk_val("A.rst_hsync", 32'(a_hs),  32'd1);
      chk_val("A.rst_vsync", 32'(a_vs),  32'd1);
      chk_val("A.rst_von",   32'(a_von), 32'd1);
      chk_val("A.rst_ptick", 32'(a_pt),  32'd0);
      chk_val("A.rst_frame", 32'(a_ft),  32'd0);
      chk_val("B.rst_ptick", 32'(b_pt),  32'd1);
      b_last_ft = -1;
    end else if (prev_ok) begin
      if (pa_hs && !a_hs)   chk_val("A.hsync_fall_x", 32'(a_x), 32'd656);
      if (!pa_hs && a_hs)   chk_val("A.hsync_rise_x", 32'(a_x), 32'd752);
      if (pa_von && !a_von && a_y == pa_y) chk_val("A.von_fall_x", 32'(a_x), 32'd640);
      if (a_y != pa_y) begin
        chk_val("A.ystep_x", 32'(a_x), 32'd0);
        chk_val("A.ystep_y", 32'(a_y), 32'(pa_y + 10'd1));
      end
      if (b_ft) begin
        if (b_last_ft >= 0) chk_val("B.frame_period", 32'(cyc - b_last_ft), 32'd40);
        b_last_ft = cyc;
      end
    end
    prev_ok = !rst;
    pa_hs = a_hs; pa_von = a_von; pa_x = a_x; pa_y = a_y;
    rst = r_in;
    n   = r_in ? 0 : n + 1;
    e.a = model(n, 2, 640, 16, 48, 96, 480, 10, 33, 2);
    e.b = model(n, 1, 4, 1, 1, 2, 2, 1, 1, 1);
    e.c = model(n, 3, 8, 2, 2, 3, 6, 2, 1, 2);
    sb_q.push_back(e);
  endtask

  initial begin
    int guard;
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Scan through the first line wrap into line 1, stopping inside the hsync pulse.
    guard = 0;
    while (!(a_x == 10'd700 && a_y == 10'd1) && guard < 4000) begin
      step(1'b0);
      guard++;
    end
    chk_val("A.reach_x700_y1", 32'(guard < 4000), 32'd1);
    chk_val("A.pre_rst_hsync", 32'(a_hs), 32'd0);

    step(1'b1);
    for (int i = 0; i < 2000; i++) step(1'b0);

    @(negedge clk);
    sb_pop_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
